// File: rtl/ysyx_23060203_ifu.sv
// Instruction fetch unit: PC, one outstanding imem read, registered {pc, inst} to decode.
// Optional ebreak halt enabled by YSYX_23060203_IFU_EBREAK_STOP_EN.
module ysyx_23060203_ifu #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
    input  logic        clk,
    input  logic        rstn,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [31:0] mem_req_addr,
    input  logic        mem_rsp_valid,
    input  logic [31:0] mem_rsp_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_inst,
    output logic [31:0] out_pc,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        halted
);

`ifdef YSYX_23060203_IFU_EBREAK_STOP_EN
    typedef enum logic [1:0] {
        S_REQ, S_WAIT, S_OUT, S_HALT
    } state_t;
`else
    typedef enum logic [1:0] {
        S_REQ, S_WAIT, S_OUT
    } state_t;
`endif

    localparam logic [31:0] EBREAK = 32'h0010_0073;

    state_t      state, state_n;
    logic [31:0] pc, pc_n;
    logic        drop, drop_n;
    logic [31:0] inst_q, inst_n;
    logic [31:0] opc_q, opc_n;
    logic [31:0] target;

    assign target        = {redirect_pc[31:2], 2'b00};
    assign mem_req_valid = rstn && (state == S_REQ);
    assign mem_req_addr  = pc;
    assign out_valid     = (state == S_OUT);
    assign out_inst      = inst_q;
    assign out_pc        = opc_q;

`ifdef YSYX_23060203_IFU_EBREAK_STOP_EN
    assign halted = (state == S_HALT);
`else
    assign halted = 1'b0;
`endif

    always_comb begin
        state_n = state;
        pc_n    = pc;
        drop_n  = drop;
        inst_n  = inst_q;
        opc_n   = opc_q;
        unique case (state)
            S_REQ: begin
                if (redirect_valid) begin
                    pc_n = target;
                    if (mem_req_ready) begin
                        state_n = S_WAIT;
                        drop_n  = 1'b1;
                    end
                end else if (mem_req_ready) begin
                    state_n = S_WAIT;
                end
            end
            S_WAIT: begin
                if (redirect_valid) begin
                    pc_n = target;
                    // a same-cycle response is the stale one; otherwise mark it
                    if (mem_rsp_valid) begin
                        state_n = S_REQ;
                        drop_n  = 1'b0;
                    end else begin
                        drop_n  = 1'b1;
                    end
                end else if (mem_rsp_valid) begin
                    if (drop) begin
                        state_n = S_REQ;
                        drop_n  = 1'b0;
                    end else begin
                        state_n = S_OUT;
                        inst_n  = mem_rsp_data;
                        opc_n   = pc;
                    end
                end
            end
            S_OUT: begin
                if (redirect_valid) begin
                    pc_n    = target;
                    state_n = S_REQ;
                end else if (out_ready) begin
                    pc_n    = pc + 32'd4;
                    state_n = S_REQ;
`ifdef YSYX_23060203_IFU_EBREAK_STOP_EN
                    if (inst_q == EBREAK) state_n = S_HALT;
`endif
                end
            end
            default: begin
                state_n = state;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state  <= S_REQ;
            pc     <= RESET_PC;
            drop   <= 1'b0;
            inst_q <= 32'h0;
            opc_q  <= RESET_PC;
        end else begin
            state  <= state_n;
            pc     <= pc_n;
            drop   <= drop_n;
            inst_q <= inst_n;
            opc_q  <= opc_n;
        end
    end

`ifndef YSYX_23060203_IFU_EBREAK_STOP_EN
    logic unused_ebreak;
    assign unused_ebreak = ^EBREAK;
`endif

endmodule

// File: tb/tb_ysyx_23060203_ifu.sv
// Directed bench for ysyx_23060203_ifu; halt checks follow YSYX_23060203_IFU_EBREAK_STOP_EN.
module tb_ysyx_23060203_ifu;

    logic        clk = 1'b0;
    logic        rstn;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_req_addr;
    logic        mem_rsp_valid;
    logic [31:0] mem_rsp_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_inst;
    logic [31:0] out_pc;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        halted;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ysyx_23060203_ifu dut (
        .clk            (clk),
        .rstn           (rstn),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_req_addr   (mem_req_addr),
        .mem_rsp_valid  (mem_rsp_valid),
        .mem_rsp_data   (mem_rsp_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_inst       (out_inst),
        .out_pc         (out_pc),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halted         (halted)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // advance one clock; inputs are then set and outputs sampled mid-cycle
    task automatic step();
        @(negedge clk);
    endtask

    initial begin
        rstn = 0; mem_req_ready = 0; mem_rsp_valid = 0; mem_rsp_data = 0;
        out_ready = 0; redirect_valid = 0; redirect_pc = 0;
        step(); step(); #1;
        chk("rst_req_valid", 32'(mem_req_valid), 32'd0);
        chk("rst_addr", mem_req_addr, 32'h8000_0000);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_inst", out_inst, 32'h0);
        chk("rst_out_pc", out_pc, 32'h8000_0000);
        chk("rst_halted", 32'(halted), 32'd0);

        // first fetch
        step(); rstn = 1; mem_req_ready = 1; #1;
        chk("f1_req_valid", 32'(mem_req_valid), 32'd1);
        chk("f1_addr", mem_req_addr, 32'h8000_0000);
        step(); mem_req_ready = 0; mem_rsp_valid = 1; mem_rsp_data = 32'h00A0_0093; #1;
        chk("f1_wait_req", 32'(mem_req_valid), 32'd0);
        chk("f1_wait_out", 32'(out_valid), 32'd0);
        step(); mem_rsp_valid = 0; mem_rsp_data = 0; out_ready = 0; #1;
        chk("f1_out_valid", 32'(out_valid), 32'd1);
        chk("f1_out_inst", out_inst, 32'h00A0_0093);
        chk("f1_out_pc", out_pc, 32'h8000_0000);

        // decode stalls for 5 cycles
        for (int i = 0; i < 5; i++) begin
            step(); #1;
            chk("hold_valid", 32'(out_valid), 32'd1);
            chk("hold_inst", out_inst, 32'h00A0_0093);
            chk("hold_pc", out_pc, 32'h8000_0000);
            chk("hold_no_req", 32'(mem_req_valid), 32'd0);
        end
        step(); out_ready = 1; #1;
        chk("f1_deliver", 32'(out_valid), 32'd1);
        step(); out_ready = 0; mem_req_ready = 1; #1;
        chk("f2_req_valid", 32'(mem_req_valid), 32'd1);
        chk("f2_addr", mem_req_addr, 32'h8000_0004);
        chk("f2_out_clear", 32'(out_valid), 32'd0);

        // redirect while waiting
        step(); mem_req_ready = 0; redirect_valid = 1; redirect_pc = 32'h8000_0102; #1;
        chk("rw_wait", 32'(mem_req_valid), 32'd0);
        step(); redirect_valid = 0; mem_rsp_valid = 1; mem_rsp_data = 32'h1234_5678; #1;
        chk("rw_out_valid", 32'(out_valid), 32'd0);
        chk("rw_no_req", 32'(mem_req_valid), 32'd0);
        step(); mem_rsp_valid = 0; #1;
        chk("rw_drop_out", 32'(out_valid), 32'd0);
        chk("rw_req_valid", 32'(mem_req_valid), 32'd1);
        chk("rw_addr", mem_req_addr, 32'h8000_0100);

        // redirect with the request handshake
        mem_req_ready = 1; redirect_valid = 1; redirect_pc = 32'h8000_0200;
        step(); mem_req_ready = 0; redirect_valid = 0; mem_rsp_valid = 1;
        mem_rsp_data = 32'hDEAD_BEEF; #1;
        chk("rh_wait", 32'(mem_req_valid), 32'd0);
        step(); mem_rsp_valid = 0; #1;
        chk("rh_out_valid", 32'(out_valid), 32'd0);
        chk("rh_req_valid", 32'(mem_req_valid), 32'd1);
        chk("rh_addr", mem_req_addr, 32'h8000_0200);
        mem_req_ready = 1;
        step(); mem_req_ready = 0; mem_rsp_valid = 1; mem_rsp_data = 32'h0000_0013; #1;
        step(); mem_rsp_valid = 0; #1;
        chk("rh_refetch_valid", 32'(out_valid), 32'd1);
        chk("rh_refetch_inst", out_inst, 32'h0000_0013);
        chk("rh_refetch_pc", out_pc, 32'h8000_0200);

        // redirect in OUT, unaligned target
        redirect_valid = 1; redirect_pc = 32'hFFFF_FFFF;
        step(); redirect_valid = 0; #1;
        chk("ro_out_valid", 32'(out_valid), 32'd0);
        chk("ro_req_valid", 32'(mem_req_valid), 32'd1);
        chk("ro_addr", mem_req_addr, 32'hFFFF_FFFC);
        mem_req_ready = 1;
        step(); mem_req_ready = 0; mem_rsp_valid = 1; mem_rsp_data = 32'h0010_0073; #1;
        step(); mem_rsp_valid = 0; out_ready = 1; #1;
        chk("eb_out_valid", 32'(out_valid), 32'd1);
        chk("eb_out_inst", out_inst, 32'h0010_0073);
        chk("eb_out_pc", out_pc, 32'hFFFF_FFFC);
        step(); out_ready = 0; #1;
`ifdef YSYX_23060203_IFU_EBREAK_STOP_EN
        chk("halt_flag", 32'(halted), 32'd1);
        chk("halt_no_req", 32'(mem_req_valid), 32'd0);
        chk("halt_out", 32'(out_valid), 32'd0);
        redirect_valid = 1; redirect_pc = 32'h8000_0000;
        step(); redirect_valid = 0; #1;
        for (int i = 0; i < 3; i++) begin
            chk("halt_stay", 32'(halted), 32'd1);
            chk("halt_stay_req", 32'(mem_req_valid), 32'd0);
            step(); #1;
        end
`else
        chk("wrap_halted", 32'(halted), 32'd0);
        chk("wrap_req_valid", 32'(mem_req_valid), 32'd1);
        chk("wrap_addr", mem_req_addr, 32'h0000_0000);
        mem_req_ready = 1;
        step(); mem_req_ready = 0; mem_rsp_valid = 1; mem_rsp_data = 32'hAAAA_5555; #1;
        step(); mem_rsp_valid = 0; #1;
        chk("wrap_out_inst", out_inst, 32'hAAAA_5555);
        chk("wrap_out_pc", out_pc, 32'h0000_0000);
`endif

        // reset mid-flight
        rstn = 0;
        step(); #1;
        chk("rr_req_valid", 32'(mem_req_valid), 32'd0);
        chk("rr_addr", mem_req_addr, 32'h8000_0000);
        chk("rr_out_valid", 32'(out_valid), 32'd0);
        chk("rr_out_inst", out_inst, 32'h0);
        chk("rr_out_pc", out_pc, 32'h8000_0000);
        chk("rr_halted", 32'(halted), 32'd0);
        step(); rstn = 1; #1;
        chk("rr_restart", 32'(mem_req_valid), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
